// File: rtl/uart_tx_nbyte.sv
// uart_tx_nbyte
// UART transmitter that sends an N-byte word as back-to-back 8N(P)S frames.
// Byte 0 (data[7:0]) goes first, each byte LSB first. The word is captured on a
// valid && ready handshake, so the source may change data while the frame is sent.
// All outputs are registered; they are loaded from next-state values so that txd,
// ready and busy change on the same clock edge as the state register.

module uart_tx_nbyte #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int NUM_BYTES    = 2,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   txd,
    output logic                   busy,
    output logic                   done
);

    localparam int WORD_W = 8 * NUM_BYTES;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BYTE_W-1:0] BYTE_ZERO = {BYTE_W{1'b0}};
    localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
    localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Parity of one byte: even parity is the XOR of the bits, odd is its inverse.
    function automatic logic parity_bit(input logic [7:0] b);
        if (PARITY == 2) begin
            return ~(^b);
        end else begin
            return ^b;
        end
    endfunction

    logic [2:0]        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [2:0]        bit_r, bit_s;
    logic [BYTE_W-1:0] byte_r, byte_s;
    logic [WORD_W-1:0] word_r, word_s;
    logic [7:0]        cur_byte_s;
    logic              done_s;
    logic              txd_s;
    logic              tick_s;

    assign tick_s = (cnt_r == CNT_MAX);

    // Next-state logic: baud counter, bit/byte indices, shift buffer and FSM.
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        word_s  = word_r;
        done_s  = 1'b0;

        if (state_r == ST_IDLE) begin
            cnt_s = CNT_ZERO;
        end else if (tick_s) begin
            cnt_s = CNT_ZERO;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                if (valid && ready) begin
                    word_s  = data;
                    byte_s  = BYTE_ZERO;
                    bit_s   = 3'd0;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    bit_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (tick_s) begin
                    bit_s   = 3'd0;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (bit_r == LAST_STOP) begin
                        bit_s = 3'd0;
                        if (byte_r != LAST_BYTE) begin
                            // Next byte moves into the low 8 bits of the buffer.
                            byte_s  = byte_r + BYTE_ONE;
                            word_s  = word_r >> 4'd8;
                            state_s = ST_START;
                        end else begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign cur_byte_s = word_s[7:0];

    // Line level for the upcoming cycle, derived from the next state.
    always_comb begin
        case (state_s)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = cur_byte_s[bit_s];
            ST_PAR:   txd_s = parity_bit(cur_byte_s);
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            byte_r  <= BYTE_ZERO;
            word_r  <= {WORD_W{1'b0}};
            txd     <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            byte_r  <= byte_s;
            word_r  <= word_s;
            txd     <= txd_s;
            ready   <= (state_s == ST_IDLE);
            busy    <= (state_s != ST_IDLE);
            done    <= done_s;
        end
    end

endmodule

// File: doc/uart_tx_nbyte.md
# uart_tx_nbyte

Parametrised UART transmitter that serialises an N-byte word as N back-to-back 8-bit frames, with optional parity and one or two stop bits. It replaces the fixed two-byte, fixed-baud transmitter in the UART path and sits between the crypto core output register and the board TxD pin. A ready/valid handshake captures the word, so the upstream block can present data and move on.

## Interface
- CLKS_PER_BIT, 10416: clock cycles per serial bit (100 MHz / 9600 baud); must be ≥ 2.
- NUM_BYTES, 2: bytes per transfer; must be ≥ 1.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- data  in  8*NUM_BYTES  word to send; byte 0 = data[7:0] goes first.
- valid  in  1  data is valid; a transfer is accepted on a rising edge where valid && ready.
- ready  out  1  high only in IDLE.
- txd  out  1  serial line; idles high; registered.
- busy  out  1  high from the cycle after accept until the transfer completes (equals !ready).
- done  out  1  one-cycle pulse when the final stop bit of the final byte completes.

## Operation
- Reset values: txd = 1, ready = 1, busy = 0, done = 0. The state, byte index, bit index and baud counter all clear to 0.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: when valid && ready, latch the whole data word into an internal shift buffer, clear the byte index, and go to START.
  - START: drive txd = 0 for one bit time, then go to DATA.
  - DATA: drive 8 bits, LSB first, each for one bit time. Then go to PAR if PARITY != 0, otherwise go to STOP.
  - PAR: drive one bit time of parity. Even parity = XOR of the 8 bits. Odd parity = its inverse.
  - STOP: drive txd = 1 for STOP_BITS bit times. Then:
    - if byte index < NUM_BYTES-1: increment the byte index and go to START, with no idle gap between bytes;
    - otherwise: pulse done and go to IDLE.
- Bit time: the baud counter runs 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. A bit advances when the counter reaches CLKS_PER_BIT-1, and the counter wraps to 0 on that cycle.
- The bit index is 3 bits; the byte index is $clog2(NUM_BYTES) bits, with a minimum of 1.
- The latched word is immune to changes on data or valid while busy. valid asserted during busy is ignored and not queued.
- Parity is computed from the latched byte, not from live data.
- Reset asserted mid-transfer aborts the transfer: the next cycle shows reset values, txd = 1, and no done pulse.

## Timing
- Accept at edge T; txd falls at edge T+1, which is the first START cycle. ready = 0 and busy = 1 from T+1.
- Frame length: F = 1 + 8 + (PARITY != 0) + STOP_BITS bits.
- Transfer length: NUM_BYTES × F × CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
- done is high for exactly one cycle: the first cycle back in IDLE, coincident with ready rising.
- Back-to-back transfers with valid held high: accept in the done cycle. This gives exactly one extra idle-high clock between transfers.
- There is no gap between bytes inside a transfer.

## Test plan
All scenarios use CLKS_PER_BIT = 4 unless noted.

- **Two-byte, no parity:** NUM_BYTES = 2, PARITY = 0, data = 16'hA55A, valid pulsed once.
  - txd bit sequence, each bit 4 cycles: 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1.
  - done pulses at 80 cycles after the first START cycle.
- **Parity:** NUM_BYTES = 1, data = 8'h07.
  - PARITY = 1: parity bit = 1.
  - PARITY = 2: parity bit = 0.
  - In both cases the frame is 11 bits = 44 cycles.
- **Two stop bits:** STOP_BITS = 2, NUM_BYTES = 2. Between bytes, txd is high for exactly 8 cycles, then falls for the next start bit.
- **Data changed while busy:** valid held high and data changed to 16'hFFFF mid-transfer.
  - The original word is sent unchanged.
  - The second word is accepted in the done cycle, and its start bit begins one cycle later.
- **Reset mid-transfer:** assert reset during DATA of byte 0.
  - Next cycle: txd = 1, ready = 1, busy = 0, done never asserts.
  - A fresh transfer afterwards is sent correctly.
- **Default rate, single byte:** CLKS_PER_BIT = 10416, NUM_BYTES = 1. Each bit lasts exactly 10416 cycles; the frame is 104160 cycles.
